// File: rtl/step_dir_decoder.sv
// step_dir_decoder: receive side of a step/dir link.
// Rebuilds a signed 64-bit position from step/dir pulses. Also reports the net
// steps per acc_step window, the clocks between the last two step edges, the
// direction of the last step, reversals, a stopped flag and a sticky
// dir-setup error.
// Optional feature: define STEP_DEC_GLITCH_FILTER_EN to add a FILT_LEN-sample
// glitch filter on the synchronised step and dir levels. This adds FILT_LEN
// clocks of edge latency.
module step_dir_decoder #(
  parameter int DIR_SETUP    = 4,
  parameter int STOP_TIMEOUT = 65536
`ifdef STEP_DEC_GLITCH_FILTER_EN
  ,parameter int FILT_LEN    = 4
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_step_in,
  input  logic        i_dir_in,
  input  logic        i_acc_step,
  input  logic        i_load,
  input  logic [63:0] i_pos_val,
  input  logic        i_clear_err,
  output logic [63:0] o_pos,
  output logic [31:0] o_win_steps,
  output logic        o_win_valid,
  output logic [31:0] o_period,
  output logic        o_dir,
  output logic        o_reversal,
  output logic        o_stopped,
  output logic        o_err_dir_setup
);

  localparam int DsW = $clog2(DIR_SETUP + 1);

  logic        r_step_s1, r_step_s2, r_dir_s1, r_dir_s2;
  logic        r_step_prev, r_dir_prev;
  logic [DsW-1:0] r_dir_stable;
  logic [63:0] r_pos;
  logic [31:0] r_win_acc, r_win_steps, r_period, r_per_cnt;
  logic        r_win_valid, r_dir, r_reversal, r_stopped, r_first_seen, r_err;

  logic        w_step_lvl, w_dir_lvl, w_edge, w_dir_changed, w_setup_ok;
  logic [63:0] w_delta64;
  logic [32:0] w_delta33, w_win_sum;
  logic [31:0] w_win_sat;

  // Two-flop synchronisers for the asynchronous step and dir pins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_dir_s1  <= 1'b0;
      r_dir_s2  <= 1'b0;
    end else begin
      r_step_s1 <= i_step_in;
      r_step_s2 <= r_step_s1;
      r_dir_s1  <= i_dir_in;
      r_dir_s2  <= r_dir_s1;
    end
  end

`ifdef STEP_DEC_GLITCH_FILTER_EN
  localparam int FcW = $clog2(FILT_LEN + 1);

  logic           r_step_filt, r_dir_filt;
  logic [FcW-1:0] r_step_fcnt, r_dir_fcnt;

  // Filtered levels follow the synced input only after FILT_LEN consecutive differing samples
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step_filt <= 1'b0;
      r_dir_filt  <= 1'b0;
      r_step_fcnt <= '0;
      r_dir_fcnt  <= '0;
    end else begin
      if (r_step_s2 != r_step_filt) begin
        if (r_step_fcnt == FcW'(FILT_LEN - 1)) begin
          r_step_filt <= r_step_s2;
          r_step_fcnt <= '0;
        end else begin
          r_step_fcnt <= r_step_fcnt + 1'b1;
        end
      end else begin
        r_step_fcnt <= '0;
      end
      if (r_dir_s2 != r_dir_filt) begin
        if (r_dir_fcnt == FcW'(FILT_LEN - 1)) begin
          r_dir_filt <= r_dir_s2;
          r_dir_fcnt <= '0;
        end else begin
          r_dir_fcnt <= r_dir_fcnt + 1'b1;
        end
      end else begin
        r_dir_fcnt <= '0;
      end
    end
  end

  assign w_step_lvl = r_step_filt;
  assign w_dir_lvl  = r_dir_filt;
`else
  assign w_step_lvl = r_step_s2;
  assign w_dir_lvl  = r_dir_s2;
`endif

  assign w_edge        = w_step_lvl & ~r_step_prev;
  assign w_dir_changed = (w_dir_lvl != r_dir_prev);
  assign w_setup_ok    = !w_dir_changed && (r_dir_stable >= DsW'(DIR_SETUP));
  assign w_delta64     = w_dir_lvl ? 64'd1 : {64{1'b1}};
  assign w_delta33     = w_edge ? (w_dir_lvl ? 33'd1 : {33{1'b1}}) : 33'd0;
  assign w_win_sum     = {r_win_acc[31], r_win_acc} + w_delta33;

  // Clamp the window sum to the signed 32-bit range when it overflows
  always_comb begin
    w_win_sat = w_win_sum[31:0];
    if (w_win_sum[32] != w_win_sum[31]) begin
      w_win_sat = w_win_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // Delayed copies of the (filtered) levels for edge and dir-change detection, plus the dir stability count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step_prev  <= 1'b0;
      r_dir_prev   <= 1'b0;
      r_dir_stable <= '0;
    end else begin
      r_step_prev <= w_step_lvl;
      r_dir_prev  <= w_dir_lvl;
      if (w_dir_changed) begin
        r_dir_stable <= '0;
      end else if (r_dir_stable < DsW'(DIR_SETUP)) begin
        r_dir_stable <= r_dir_stable + 1'b1;
      end
    end
  end

  // Position: a preset load takes priority over a step in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos <= '0;
    end else if (i_load) begin
      r_pos <= i_pos_val;
    end else if (w_edge) begin
      r_pos <= r_pos + w_delta64;
    end
  end

  // Window accumulator; the closing strobe includes a step arriving in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_win_acc   <= '0;
      r_win_steps <= '0;
      r_win_valid <= 1'b0;
    end else if (i_acc_step) begin
      r_win_steps <= w_win_sat;
      r_win_acc   <= '0;
      r_win_valid <= 1'b1;
    end else begin
      r_win_acc   <= w_win_sat;
      r_win_valid <= 1'b0;
    end
  end

  // Step period counter and stopped detection; the first edge after reset reports all-ones
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_per_cnt <= '1;
      r_period  <= '1;
      r_stopped <= 1'b1;
    end else if (w_edge) begin
      r_period  <= r_per_cnt;
      r_per_cnt <= 32'd1;
      r_stopped <= 1'b0;
    end else begin
      if (r_per_cnt != '1) begin
        r_per_cnt <= r_per_cnt + 32'd1;
      end
      r_stopped <= (r_per_cnt >= 32'(STOP_TIMEOUT));
    end
  end

  // Direction of the last step and reversal pulse once a previous step has been seen
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dir        <= 1'b0;
      r_reversal   <= 1'b0;
      r_first_seen <= 1'b0;
    end else begin
      r_reversal <= w_edge && r_first_seen && (w_dir_lvl != r_dir);
      if (w_edge) begin
        r_dir        <= w_dir_lvl;
        r_first_seen <= 1'b1;
      end
    end
  end

  // Sticky dir-setup error; a new violation beats a same-cycle clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (w_edge && !w_setup_ok) begin
      r_err <= 1'b1;
    end else if (i_clear_err) begin
      r_err <= 1'b0;
    end
  end

  assign o_pos           = r_pos;
  assign o_win_steps     = r_win_steps;
  assign o_win_valid     = r_win_valid;
  assign o_period        = r_period;
  assign o_dir           = r_dir;
  assign o_reversal      = r_reversal;
  assign o_stopped       = r_stopped;
  assign o_err_dir_setup = r_err;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Testbench for step_dir_decoder: table of step bursts plus hand-written corner sequences.
module tb_step_dir_decoder;

  localparam int STO = 1024;
`ifdef STEP_DEC_GLITCH_FILTER_EN
  localparam int H   = 4;
  localparam int LAT = 7;
`else
  localparam int H   = 2;
  localparam int LAT = 3;
`endif

  logic        i_clk, i_reset, i_step_in, i_dir_in, i_acc_step, i_load, i_clear_err;
  logic [63:0] i_pos_val;
  logic [63:0] o_pos;
  logic [31:0] o_win_steps, o_period;
  logic        o_win_valid, o_dir, o_reversal, o_stopped, o_err_dir_setup;

  int total = 0;
  int bad = 0;
  int revCount = 0;
  int wvCount = 0;

  typedef struct {
    logic        dir;
    int          n;
    int          hi;
    int          lo;
    logic [63:0] expPos;
    logic        expDir;
    logic [31:0] expPeriod;
    logic [31:0] expWin;
    int          expRev;
  } vec_t;

  vec_t vecs[5];

  step_dir_decoder #(.DIR_SETUP(4), .STOP_TIMEOUT(STO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_step_in(i_step_in), .i_dir_in(i_dir_in),
    .i_acc_step(i_acc_step), .i_load(i_load), .i_pos_val(i_pos_val), .i_clear_err(i_clear_err),
    .o_pos(o_pos), .o_win_steps(o_win_steps), .o_win_valid(o_win_valid), .o_period(o_period),
    .o_dir(o_dir), .o_reversal(o_reversal), .o_stopped(o_stopped), .o_err_dir_setup(o_err_dir_setup)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Count single-cycle pulses away from the active edge
  always @(negedge i_clk) begin
    if (o_reversal) revCount++;
    if (o_win_valid) wvCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic stepPulse(input int hi, input int lo);
    i_step_in = 1'b1;
    tick(hi);
    i_step_in = 1'b0;
    tick(lo);
  endtask

  task automatic accPulse();
    i_acc_step = 1'b1;
    tick(1);
    i_acc_step = 1'b0;
    tick(1);
  endtask

  // One step whose decoder-side edge cycle coincides with the given strobes
  task automatic edgeWithStrobes(input logic ld, input logic acc, input logic clr);
    i_step_in = 1'b1;
    tick(LAT - 1);
    i_load = ld;
    i_acc_step = acc;
    i_clear_err = clr;
    tick(1);
    i_load = 1'b0;
    i_acc_step = 1'b0;
    i_clear_err = 1'b0;
    tick(H);
    i_step_in = 1'b0;
    tick(8);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int revStart;
    int wvStart;
    i_dir_in = v.dir;
    tick(10);
    revStart = revCount;
    wvStart = wvCount;
    for (int k = 0; k < v.n; k++) stepPulse(v.hi, v.lo);
    tick(LAT + 2);
    accPulse();
    tick(1);
    checkOutput($sformatf("row%0d_pos", idx), o_pos, v.expPos);
    checkOutput($sformatf("row%0d_dir", idx), 64'(o_dir), 64'(v.expDir));
    checkOutput($sformatf("row%0d_period", idx), 64'(o_period), 64'(v.expPeriod));
    checkOutput($sformatf("row%0d_stopped", idx), 64'(o_stopped), 64'd0);
    checkOutput($sformatf("row%0d_err", idx), 64'(o_err_dir_setup), 64'd0);
    checkOutput($sformatf("row%0d_win", idx), 64'(o_win_steps), 64'(v.expWin));
    checkOutput($sformatf("row%0d_rev", idx), 64'(revCount - revStart), 64'(v.expRev));
    checkOutput($sformatf("row%0d_winvalid", idx), 64'(wvCount - wvStart), 64'd1);
  endtask

  initial begin
    int revStart;
    vecs[0] = '{1'b1, 10, H, 8 - H,  64'd10, 1'b1, 32'd8,  32'd10,         0};
    vecs[1] = '{1'b0, 3,  H, 8 - H,  64'd7,  1'b0, 32'd8,  32'hFFFF_FFFD,  1};
    vecs[2] = '{1'b1, 5,  4, 8,      64'd12, 1'b1, 32'd12, 32'd5,          1};
    vecs[3] = '{1'b0, 2,  5, 5,      64'd10, 1'b0, 32'd10, 32'hFFFF_FFFE,  1};
    vecs[4] = '{1'b0, 4,  H, 12 - H, 64'd6,  1'b0, 32'd12, 32'hFFFF_FFFC,  0};

    i_reset = 1'b1; i_step_in = 1'b0; i_dir_in = 1'b0; i_acc_step = 1'b0;
    i_load = 1'b0; i_pos_val = '0; i_clear_err = 1'b0;
    tick(3);
    checkOutput("rst_pos", o_pos, 64'd0);
    checkOutput("rst_win", 64'(o_win_steps), 64'd0);
    checkOutput("rst_winvalid", 64'(o_win_valid), 64'd0);
    checkOutput("rst_period", 64'(o_period), 64'hFFFF_FFFF);
    checkOutput("rst_dir", 64'(o_dir), 64'd0);
    checkOutput("rst_reversal", 64'(o_reversal), 64'd0);
    checkOutput("rst_stopped", 64'(o_stopped), 64'd1);
    checkOutput("rst_err", 64'(o_err_dir_setup), 64'd0);
    i_reset = 1'b0;
    tick(2);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    $display("[TB] wrap on load of max positive value");
    i_pos_val = 64'h7FFF_FFFF_FFFF_FFFF;
    i_load = 1'b1; tick(1); i_load = 1'b0; tick(1);
    checkOutput("load_pos", o_pos, 64'h7FFF_FFFF_FFFF_FFFF);
    i_dir_in = 1'b1; tick(10);
    stepPulse(H, 8 - H); tick(LAT);
    checkOutput("wrap_pos", o_pos, 64'h8000_0000_0000_0000);
    checkOutput("wrap_dir", 64'(o_dir), 64'd1);

    $display("[TB] dir setup violations");
    i_dir_in = 1'b0; tick(1);
    stepPulse(H, 8 - H); tick(2);
    checkOutput("setup_err_set", 64'(o_err_dir_setup), 64'd1);
    checkOutput("setup_step_counted", o_pos, 64'h7FFF_FFFF_FFFF_FFFF);
    i_clear_err = 1'b1; tick(1); i_clear_err = 1'b0; tick(1);
    checkOutput("setup_err_cleared", 64'(o_err_dir_setup), 64'd0);
    i_dir_in = 1'b1; tick(1);
    edgeWithStrobes(1'b0, 1'b0, 1'b1); tick(2);
    checkOutput("setup_set_beats_clear", 64'(o_err_dir_setup), 64'd1);
    checkOutput("setup_pos2", o_pos, 64'h8000_0000_0000_0000);
    tick(10);
    i_clear_err = 1'b1; tick(1); i_clear_err = 1'b0; tick(1);
    stepPulse(H, 8 - H); tick(2);
    checkOutput("setup_clean_step", 64'(o_err_dir_setup), 64'd0);
    checkOutput("setup_clean_pos", o_pos, 64'h8000_0000_0000_0001);

    $display("[TB] load and edge in the same cycle");
    accPulse();
    i_pos_val = 64'd100;
    edgeWithStrobes(1'b1, 1'b0, 1'b0); tick(2);
    checkOutput("loadedge_pos", o_pos, 64'd100);
    accPulse();
    checkOutput("loadedge_win", 64'(o_win_steps), 64'd1);

    $display("[TB] window close in the same cycle as an edge");
    i_dir_in = 1'b0; tick(10);
    edgeWithStrobes(1'b0, 1'b1, 1'b0); tick(1);
    checkOutput("accedge_win", 64'(o_win_steps), 64'hFFFF_FFFF);
    checkOutput("accedge_pos", o_pos, 64'd99);
    accPulse();
    checkOutput("accedge_next_win", 64'(o_win_steps), 64'd0);

    $display("[TB] stop timeout");
    tick(STO - 40);
    checkOutput("stopped_before", 64'(o_stopped), 64'd0);
    tick(60);
    checkOutput("stopped_after", 64'(o_stopped), 64'd1);
    stepPulse(H, 8 - H);
    checkOutput("stopped_cleared", 64'(o_stopped), 64'd0);
    checkOutput("stopped_pos", o_pos, 64'd98);

`ifdef STEP_DEC_GLITCH_FILTER_EN
    $display("[TB] glitch filter pulses");
    i_step_in = 1'b1; tick(2); i_step_in = 1'b0; tick(20);
    checkOutput("filter_short_dropped", o_pos, 64'd98);
    i_step_in = 1'b1; tick(6); i_step_in = 1'b0; tick(20);
    checkOutput("filter_long_counted", o_pos, 64'd97);
`else
    $display("[TB] single-clock pulse");
    i_step_in = 1'b1; tick(1); i_step_in = 1'b0; tick(10);
    checkOutput("short_pulse_counted", o_pos, 64'd97);
`endif

    $display("[TB] reset mid-motion with step held high");
    i_dir_in = 1'b1; tick(10);
    i_step_in = 1'b1; tick(1);
    i_reset = 1'b1; tick(2);
    checkOutput("midrst_pos", o_pos, 64'd0);
    checkOutput("midrst_period", 64'(o_period), 64'hFFFF_FFFF);
    checkOutput("midrst_stopped", 64'(o_stopped), 64'd1);
    checkOutput("midrst_dir", 64'(o_dir), 64'd0);
    checkOutput("midrst_win", 64'(o_win_steps), 64'd0);
    revStart = revCount;
    i_reset = 1'b0;
    tick(LAT + 3);
    i_step_in = 1'b0;
    tick(6);
    checkOutput("postrst_pos", o_pos, 64'd1);
    checkOutput("postrst_period", 64'(o_period), 64'hFFFF_FFFF);
    checkOutput("postrst_dir", 64'(o_dir), 64'd1);
    checkOutput("postrst_stopped", 64'(o_stopped), 64'd0);
    checkOutput("postrst_err", 64'(o_err_dir_setup), 64'd1);
    checkOutput("postrst_no_reversal", 64'(revCount - revStart), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
